// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares a single uart_tx serializer among NUM_REQ byte
//             requesters using round-robin arbitration. Only one frame is
//             in flight at a time. The arbiter launches a frame with a
//             one-cycle tx_start pulse, watches tx_busy rise and fall, and
//             gives up with a start_err pulse if the serializer never
//             acknowledges the start.
//  Ports    :
//    clk        in   system clock
//    reset_n    in   asynchronous active-low reset
//    req        in   per-requester send request (level)
//    req_data   in   requester i byte in [i*DATA_W +: DATA_W]
//    grant      out  one-hot, one-cycle pulse: byte i accepted
//    tx_start   out  one-cycle start pulse to uart_tx
//    tx_data    out  byte to uart_tx, held from start until frame end
//    tx_busy    in   uart_tx frame in progress
//    arb_busy   out  high whenever the FSM is not idle
//    grant_idx  out  index of the last granted requester
//    start_err  out  one-cycle pulse: tx_busy never rose after tx_start
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic                       arb_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       start_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_START     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]         state_q,     state_d;
    logic [IDX_W-1:0]   ptr_q,       ptr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [NUM_REQ-1:0] grant_q,     grant_d;
    logic               tx_start_q,  tx_start_d;
    logic [DATA_W-1:0]  tx_data_q,   tx_data_d;
    logic               arb_busy_q,  arb_busy_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               start_err_q, start_err_d;

    // ------------------------------------------------------------------
    // Requester byte unpacking
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Round-robin winner search: scan from the pointer upward, wrapping
    // at NUM_REQ. The sum is one bit wider than the index so that the
    // wrap works for non-power-of-two requester counts too.
    // ------------------------------------------------------------------
    logic [IDX_W:0]    w_sum;
    logic [IDX_W-1:0]  w_cand;
    logic              w_found;
    logic [IDX_W-1:0]  w_winner;
    logic [DATA_W-1:0] w_win_data;
    logic [IDX_W-1:0]  w_ptr_next;
    logic              w_launch;
    logic [CNT_W-1:0]  w_cnt_inc;

    always_comb begin
        w_sum      = '0;
        w_cand     = '0;
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found    = 1'b1;
                w_winner   = w_cand;
                w_win_data = w_bytes[w_cand];
            end
        end
    end

    assign w_ptr_next = (w_winner == c_LAST_IDX) ? '0 : w_winner + IDX_W'(1);
    assign w_launch   = (state_q == c_ST_IDLE) && w_found && !tx_busy;
    assign w_cnt_inc  = cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // State register (plus all registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= c_ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            arb_busy_q  <= 1'b0;
            grant_idx_q <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            arb_busy_q  <= arb_busy_d;
            grant_idx_q <= grant_idx_d;
            start_err_q <= start_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_launch) begin
                    state_d = c_ST_START;
                end
            end
            c_ST_START: begin
                state_d = c_ST_WAIT_BUSY;
            end
            c_ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = c_ST_WAIT_DONE;
                end else if (w_cnt_inc == c_CNT_LAST) begin
                    state_d = c_ST_IDLE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. grant and tx_start default to low so
    // they only survive the single START cycle.
    // ------------------------------------------------------------------
    always_comb begin
        grant_d     = '0;
        tx_start_d  = 1'b0;
        start_err_d = 1'b0;
        tx_data_d   = tx_data_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        arb_busy_d  = (state_d != c_ST_IDLE);
        case (state_q)
            c_ST_IDLE: begin
                if (w_launch) begin
                    grant_d     = NUM_REQ'(1) << w_winner;
                    tx_start_d  = 1'b1;
                    tx_data_d   = w_win_data;
                    grant_idx_d = w_winner;
                    ptr_d       = w_ptr_next;
                end
            end
            c_ST_START: begin
                cnt_d = '0;
            end
            c_ST_WAIT_BUSY: begin
                if (!tx_busy) begin
                    // The byte is dropped on timeout; the pointer has
                    // already moved past the requester and is not rewound.
                    if (w_cnt_inc == c_CNT_LAST) begin
                        start_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign grant     = grant_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign arb_busy  = arb_busy_q;
    assign grant_idx = grant_idx_q;
    assign start_err = start_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter. Expected grants are
//             queued when stimulus is applied and popped by a monitor when
//             the arbiter pulses tx_start. A small uart_tx model serializes
//             each frame (LSB first, start/stop bits) and compares the line
//             against queued expected bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 8;
    localparam int START_TIMEOUT = 8;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] idx;
        logic [7:0] d;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tb_busy;
    logic        arb_busy;
    logic [1:0]  grant_idx;
    logic        start_err;

    logic        model_on;
    logic        force_busy;
    logic        allow_err;

    int total;
    int bad;

    exp_t       sb[$];
    logic [7:0] ser_q[$];

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_W        (DATA_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tb_busy),
        .arb_busy  (arb_busy),
        .grant_idx (grant_idx),
        .start_err (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // uart_tx model: 4 clocks per bit, frame = start, 8 data LSB first, stop
    // ------------------------------------------------------------------
    logic       m_busy;
    logic [9:0] m_frame;
    logic [3:0] m_bit;
    logic [1:0] m_ph;
    logic       line;
    logic [9:0] got;

    assign line    = m_busy ? m_frame[m_bit] : 1'b1;
    assign tb_busy = model_on ? m_busy : force_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_frame <= '0;
            m_bit   <= '0;
            m_ph    <= '0;
        end else if (!m_busy) begin
            if (model_on && tx_start) begin
                m_busy  <= 1'b1;
                m_frame <= {1'b1, tx_data, 1'b0};
                m_bit   <= '0;
                m_ph    <= '0;
            end
        end else begin
            m_ph <= m_ph + 2'd1;
            if (m_ph == 2'd3) begin
                if (m_bit == 4'd9) m_busy <= 1'b0;
                else               m_bit  <= m_bit + 4'd1;
            end
        end
    end

    // Line sampler: mid-bit capture, frame compare on the stop bit
    always @(negedge clk) begin
        if (reset_n && m_busy) begin
            chk("tx_data_hold", tx_data, m_frame[8:1]);
            if (m_ph == 2'd1) begin
                got[m_bit] = line;
                if (m_bit == 4'd9) begin
                    chk("ser_expected", (ser_q.size() != 0), 1);
                    if (ser_q.size() != 0) begin
                        logic [7:0] eb;
                        eb = ser_q.pop_front();
                        chk("serial_frame", got, {1'b1, eb, 1'b0});
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    logic prev_start;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                chk("start_width", prev_start, 0);
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("grant", grant, e.g);
                    chk("grant_idx", grant_idx, e.idx);
                    chk("tx_data", tx_data, e.d);
                end
            end else begin
                chk("grant_idle", grant, 0);
            end
            if (!allow_err) chk("spurious_err", start_err, 0);
            prev_start = tx_start;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 4'd0 && n < 200);
        chk("grant_seen", (grant != 4'd0), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((arb_busy || tb_busy) && n < 500);
        chk("arb_idle", arb_busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},     grant,     0);
        chk({tag, "_tx_start"},  tx_start,  0);
        chk({tag, "_tx_data"},   tx_data,   0);
        chk({tag, "_arb_busy"},  arb_busy,  0);
        chk({tag, "_grant_idx"}, grant_idx, 0);
        chk({tag, "_start_err"}, start_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int cnt;
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        req        = '0;
        req_data   = '0;
        model_on   = 1'b1;
        force_busy = 1'b0;
        allow_err  = 1'b0;
        prev_start = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b1;

        // single request from requester 1, byte 0xAA
        sb.push_back('{4'b0010, 2'd1, 8'hAA});
        ser_q.push_back(8'hAA);
        req_data = {8'h00, 8'h00, 8'hAA, 8'h00};
        req      = 4'b0010;
        wait_grant(n);
        chk("req_to_grant_latency", n, 1);
        req = '0;
        wait_idle();

        // reset in the middle of a frame (pointer is 2 here)
        sb.push_back('{4'b0100, 2'd2, 8'h5C});
        req_data = {8'h00, 8'h5C, 8'h00, 8'h00};
        req      = 4'b0100;
        wait_grant(n);
        req = '0;
        n = 0;
        while (!tb_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_start) cnt++;
        end
        chk("no_start_after_reset", cnt, 0);

        // round robin with all four requesting: 0,1,2,3,0
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        sb.push_back('{4'b0001, 2'd0, 8'h10}); ser_q.push_back(8'h10);
        sb.push_back('{4'b0010, 2'd1, 8'h21}); ser_q.push_back(8'h21);
        sb.push_back('{4'b0100, 2'd2, 8'h32}); ser_q.push_back(8'h32);
        sb.push_back('{4'b1000, 2'd3, 8'h43}); ser_q.push_back(8'h43);
        sb.push_back('{4'b0001, 2'd0, 8'h10}); ser_q.push_back(8'h10);
        req = 4'b1111;
        repeat (5) wait_grant(n);
        req = '0;
        wait_idle();

        // wrap: bring pointer to 3, then 0101 -> 0, 2, 0
        req_data = {8'h00, 8'hC3, 8'h00, 8'h5A};
        sb.push_back('{4'b0100, 2'd2, 8'hC3}); ser_q.push_back(8'hC3);
        sb.push_back('{4'b0001, 2'd0, 8'h5A}); ser_q.push_back(8'h5A);
        sb.push_back('{4'b0100, 2'd2, 8'hC3}); ser_q.push_back(8'hC3);
        sb.push_back('{4'b0001, 2'd0, 8'h5A}); ser_q.push_back(8'h5A);
        req = 4'b0100;
        wait_grant(n);
        req = 4'b0101;
        repeat (3) wait_grant(n);
        req = '0;
        wait_idle();

        // start timeout: serializer never raises busy
        model_on   = 1'b0;
        force_busy = 1'b0;
        allow_err  = 1'b1;
        sb.push_back('{4'b1000, 2'd3, 8'h7E});
        req_data = {8'h7E, 8'h00, 8'h00, 8'h00};
        req      = 4'b1000;
        wait_grant(n);
        req = '0;
        n = 0;
        while (!start_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, START_TIMEOUT);
        chk("idle_at_err", arb_busy, 0);
        @(negedge clk);
        chk("err_pulse_width", start_err, 0);
        allow_err = 1'b0;
        model_on  = 1'b1;
        sb.push_back('{4'b0001, 2'd0, 8'h3C});
        ser_q.push_back(8'h3C);
        req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
        req      = 4'b0001;
        wait_grant(n);
        req = '0;
        wait_idle();

        // withdraw: req[1] raised during frame 0 and dropped in WAIT_DONE
        sb.push_back('{4'b0001, 2'd0, 8'h99});
        ser_q.push_back(8'h99);
        req_data = {8'h00, 8'h00, 8'h66, 8'h99};
        req      = 4'b0001;
        wait_grant(n);
        req = 4'b0010;
        n = 0;
        while (!tb_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req = '0;
        wait_idle();
        repeat (10) @(negedge clk);

        // contention: serializer busy while idle holds off arbitration
        model_on   = 1'b0;
        force_busy = 1'b1;
        req_data   = {8'h00, 8'h00, 8'h00, 8'h42};
        req        = 4'b0001;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_start) cnt++;
        end
        chk("no_start_while_busy", cnt, 0);
        chk("idle_while_busy", arb_busy, 0);
        sb.push_back('{4'b0001, 2'd0, 8'h42});
        ser_q.push_back(8'h42);
        model_on = 1'b1;
        wait_grant(n);
        chk("busy_release_latency", n, 1);
        req = '0;
        wait_idle();

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("ser_drained", ser_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
